// File: rtl/tx_arb4_pkg.sv
// Shared types and constants for the four-client transmit arbiter.
package tx_arb4_pkg;

   localparam int N_CLIENTS = 4;
   localparam int GAP_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   function automatic logic [N_CLIENTS-1:0] onehot4(input logic [1:0] idx);
      onehot4 = N_CLIENTS'(1) << idx;
   endfunction

endpackage

// File: rtl/tx_arb4_pri_en4.sv
// Four-input priority encoder; the highest set index wins.
module pri_en4 (
   input  logic [3:0] i_req,
   output logic [1:0] o_idx,
   output logic       o_hit
);

   always_comb begin
      o_idx = 2'd0;
      if (i_req[3])      o_idx = 2'd3;
      else if (i_req[2]) o_idx = 2'd2;
      else if (i_req[1]) o_idx = 2'd1;
      else               o_idx = 2'd0;
   end

   assign o_hit = |i_req;

endmodule

// File: rtl/tx_arb4.sv
// Fixed-priority packet arbiter: four client byte streams onto one
// transmit stream, grant held per packet, programmable inter-packet gap.
module tx_arb4
   import tx_arb4_pkg::*;
#(
   parameter int DW  = 8,
   parameter int IPG = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CLIENTS-1:0]    req,
   input  logic [N_CLIENTS*DW-1:0] din,
   input  logic [N_CLIENTS-1:0]    eop,
   output logic [N_CLIENTS-1:0]    gnt,
   output logic [1:0]              owner,
   output logic                    busy,
   output logic [DW-1:0]           dout,
   output logic                    dout_valid,
   output logic                    dout_last,
   output logic                    dout_abort
);

   localparam logic [GAP_W-1:0] LP_IPG = GAP_W'(IPG);
   localparam state_t LP_END = (IPG == 0) ? ST_IDLE : ST_GAP;
   localparam logic LP_END_BUSY = (IPG != 0);

   state_t               r_state;
   logic [GAP_W-1:0]     r_gap;
   logic [N_CLIENTS-1:0] r_gnt;
   logic [1:0]           r_owner;
   logic                 r_busy;
   logic [DW-1:0]        r_dout;
   logic                 r_valid;
   logic                 r_last;
   logic                 r_abort;

   logic [1:0]    w_idx;
   logic          w_hit;
   logic [DW-1:0] w_din;
   logic          w_eop;
   logic          w_req;

   pri_en4 u_pri (
      .i_req (req),
      .o_idx (w_idx),
      .o_hit (w_hit)
   );

   assign w_din = din[r_owner*DW +: DW];
   assign w_eop = eop[r_owner];
   assign w_req = req[r_owner];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gap   <= '0;
         r_gnt   <= '0;
         r_owner <= '0;
         r_busy  <= 1'b0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_hit) begin
                  r_owner <= w_idx;
                  r_gnt   <= onehot4(w_idx);
                  r_busy  <= 1'b1;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               r_dout <= w_din;
               // eop wins over a dropped req on the same beat
               if (w_eop || !w_req) begin
                  r_valid <= w_eop;
                  r_last  <= w_eop;
                  r_abort <= !w_eop;
                  r_gnt   <= '0;
                  r_gap   <= LP_IPG;
                  r_busy  <= LP_END_BUSY;
                  r_state <= LP_END;
               end else begin
                  r_valid <= 1'b1;
               end
            end
            ST_GAP: begin
               r_gap <= r_gap - 1'b1;
               if (r_gap <= GAP_W'(1)) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign owner      = r_owner;
   assign busy       = r_busy;
   assign dout       = r_dout;
   assign dout_valid = r_valid;
   assign dout_last  = r_last;
   assign dout_abort = r_abort;

endmodule

// File: tb/tb_tx_arb4.sv
// Bench for tx_arb4: IPG=12 and IPG=0 instances checked every cycle
// against a time-based model, plus directed packet scenarios.
module tb_tx_arb4;

   localparam int IPG_A = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [3:0]  eop = '0;
   logic [31:0] din = '0;

   logic [3:0] g  [2];
   logic [1:0] ow [2];
   logic       bz [2];
   logic       v  [2];
   logic       l  [2];
   logic       a  [2];
   logic [7:0] d  [2];

   always #5 clk = ~clk;

   tx_arb4 #(.DW(8), .IPG(IPG_A)) u_a (
      .clk(clk), .rst(rst), .req(req), .din(din), .eop(eop),
      .gnt(g[0]), .owner(ow[0]), .busy(bz[0]), .dout(d[0]),
      .dout_valid(v[0]), .dout_last(l[0]), .dout_abort(a[0])
   );

   tx_arb4 #(.DW(8), .IPG(0)) u_b (
      .clk(clk), .rst(rst), .req(req), .din(din), .eop(eop),
      .gnt(g[1]), .owner(ow[1]), .busy(bz[1]), .dout(d[1]),
      .dout_valid(v[1]), .dout_last(l[1]), .dout_abort(a[1])
   );

   // Model: owner index (-1 = none) and the first edge at which
   // arbitration is allowed again.
   int         cyc = 0;
   int         m_own  [2];
   int         m_free [2];
   logic [3:0] e_g  [2];
   logic [1:0] e_ow [2];
   logic       e_bz [2];
   logic       e_v  [2];
   logic       e_l  [2];
   logic       e_a  [2];
   logic [7:0] e_d  [2];

   function automatic int top_req(logic [3:0] r);
      for (int k = 3; k >= 0; k--)
         if (r[k]) return k;
      return -1;
   endfunction

   task automatic mstep(int x, int ipg);
      int o;
      e_v[x] = 1'b0;
      e_l[x] = 1'b0;
      e_a[x] = 1'b0;
      o = m_own[x];
      if (o >= 0) begin
         e_d[x] = din[o*8 +: 8];
         if (eop[o] || !req[o]) begin
            e_v[x] = eop[o];
            e_l[x] = eop[o];
            e_a[x] = !eop[o];
            m_own[x]  = -1;
            m_free[x] = cyc + 1 + ipg;
         end else begin
            e_v[x] = 1'b1;
         end
      end else if (cyc >= m_free[x] && top_req(req) >= 0) begin
         m_own[x] = top_req(req);
         e_ow[x]  = 2'(m_own[x]);
      end
      e_g[x]  = (m_own[x] >= 0) ? (4'b0001 << m_own[x]) : 4'b0000;
      e_bz[x] = (m_own[x] >= 0) || (cyc + 1 < m_free[x]);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int x = 0; x < 2; x++) begin
            m_own[x] = -1; m_free[x] = 0;
            e_g[x] = '0; e_ow[x] = '0; e_bz[x] = 1'b0;
            e_v[x] = 1'b0; e_l[x] = 1'b0; e_a[x] = 1'b0; e_d[x] = '0;
         end
      end else begin
         cyc = cyc + 1;
         mstep(0, IPG_A);
         mstep(1, 0);
      end
   end

   typedef struct { int c; logic [7:0] d; logic l; } beat_t;
   beat_t lg0[$];
   beat_t lg1[$];
   int    ab0 = 0;
   int    total = 0;
   int    bad = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(int k, logic [7:0] b0, int n, bit ab, int sel,
                           output int w, output logic [3:0] gs);
      bit got;
      got = 1'b0;
      w = 0;
      gs = '0;
      req[k] = 1'b1;
      eop[k] = 1'b0;
      while (!got && w < 300) begin
         tick();
         w++;
         if (g[sel][k]) begin
            got = 1'b1;
            gs = g[sel];
         end
      end
      if (!got) chk("gnt_timeout", 64'd0, 64'd1);
      for (int i = 0; i < n; i++) begin
         din[k*8 +: 8] = b0 + 8'(i*17);
         eop[k] = (i == n-1) && !ab;
         tick();
      end
      req[k] = 1'b0;
      eop[k] = 1'b0;
   endtask

   int         w1, w2, c0, abs;
   logic [3:0] gs1, gs2;
   logic [7:0] ex2 [4];

   initial begin
      ex2 = '{8'h11, 8'h22, 8'h33, 8'h44};
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               for (int x = 0; x < 2; x++)
                  chk(x == 0 ? "cycle_ipg12" : "cycle_ipg0",
                      64'({g[x], ow[x], bz[x], v[x], l[x], a[x],
                           v[x] ? d[x] : 8'h00, $isunknown(d[x])}),
                      64'({e_g[x], e_ow[x], e_bz[x], e_v[x], e_l[x], e_a[x],
                           e_v[x] ? e_d[x] : 8'h00, 1'b0}));
               if (v[0]) lg0.push_back('{cyc, d[0], l[0]});
               if (v[1]) lg1.push_back('{cyc, d[1], l[1]});
               if (a[0]) ab0++;
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) tick();
      for (int x = 0; x < 2; x++)
         chk("idle_zero",
             64'({g[x], ow[x], bz[x], v[x], l[x], a[x], d[x]}), 64'd0);

      // single client, 4-byte packet
      lg0.delete();
      c0 = cyc;
      send_pkt(1, 8'h11, 4, 1'b0, 0, w1, gs1);
      chk("single_gnt_wait", 64'(w1), 64'd1);
      chk("single_gnt", 64'(gs1), 64'(4'b0010));
      repeat (2) tick();
      chk("single_nbeats", 64'(lg0.size()), 64'd4);
      for (int i = 0; i < lg0.size() && i < 4; i++)
         chk("single_byte", 64'({lg0[i].d, lg0[i].l}), 64'({ex2[i], i == 3}));
      if (lg0.size() > 0) chk("single_latency", 64'(lg0[0].c - c0), 64'd2);

      // contention: 2 wins, 0 follows after the gap
      repeat (20) tick();
      lg0.delete();
      fork
         send_pkt(2, 8'hA0, 3, 1'b0, 0, w1, gs1);
         send_pkt(0, 8'h50, 2, 1'b0, 0, w2, gs2);
      join
      repeat (2) tick();
      chk("cont_gnt_hi", 64'(gs1), 64'(4'b0100));
      chk("cont_gnt_lo", 64'(gs2), 64'(4'b0001));
      chk("cont_nbeats", 64'(lg0.size()), 64'd5);
      if (lg0.size() >= 5) begin
         chk("cont_first", 64'(lg0[0].d), 64'h A0);
         chk("cont_second", 64'(lg0[3].d), 64'h50);
         chk("cont_gap", 64'(lg0[3].c - lg0[2].c), 64'(IPG_A + 2));
      end

      // no preemption by a higher client mid-packet
      repeat (20) tick();
      lg0.delete();
      fork
         send_pkt(0, 8'h30, 5, 1'b0, 0, w1, gs1);
         begin
            repeat (3) tick();
            send_pkt(3, 8'h70, 2, 1'b0, 0, w2, gs2);
         end
      join
      repeat (2) tick();
      chk("nopre_gnt3", 64'(gs2), 64'(4'b1000));
      chk("nopre_nbeats", 64'(lg0.size()), 64'd7);
      if (lg0.size() >= 7) begin
         chk("nopre_last0", 64'({lg0[4].d, lg0[4].l}), 64'({8'h74, 1'b1}));
         chk("nopre_first3", 64'(lg0[5].d), 64'h70);
         chk("nopre_gap", 64'(lg0[5].c - lg0[4].c), 64'(IPG_A + 2));
      end

      // abort: req dropped after 2 bytes without eop
      repeat (20) tick();
      lg0.delete();
      abs = ab0;
      send_pkt(2, 8'h90, 2, 1'b1, 0, w1, gs1);
      tick();
      chk("abort_cycle", 64'({a[0], v[0], g[0], bz[0]}),
          64'({1'b1, 1'b0, 4'b0000, 1'b1}));
      tick();
      chk("abort_pulse", 64'(a[0]), 64'd0);
      tick();
      chk("abort_count", 64'(ab0 - abs), 64'd1);
      chk("abort_nbeats", 64'(lg0.size()), 64'd2);
      if (lg0.size() >= 2) chk("abort_nolast", 64'(lg0[1].l), 64'd0);

      // IPG=0 back-to-back single-byte packets
      repeat (20) tick();
      lg1.delete();
      send_pkt(1, 8'h05, 1, 1'b0, 1, w1, gs1);
      send_pkt(1, 8'h06, 1, 1'b0, 1, w2, gs2);
      repeat (2) tick();
      chk("b2b_regrant", 64'(w2), 64'd1);
      chk("b2b_nbeats", 64'(lg1.size()), 64'd2);
      if (lg1.size() >= 2) begin
         chk("b2b_spacing", 64'(lg1[1].c - lg1[0].c), 64'd2);
         chk("b2b_beats", 64'({lg1[0].d, lg1[0].l, lg1[1].d, lg1[1].l}),
             64'({8'h05, 1'b1, 8'h06, 1'b1}));
      end

      // reset asserted mid-packet
      repeat (20) tick();
      fork
         send_pkt(3, 8'hE0, 6, 1'b0, 0, w1, gs1);
         begin
            repeat (3) tick();
            chk("rst_pre", 64'({v[0], bz[0]}), 64'(2'b11));
            #2 rst = 1'b1;
            #1 chk("rst_mid", 64'({g[0], v[0], l[0], bz[0], a[0], d[0]}), 64'd0);
            @(negedge clk);
            rst = 1'b0;
         end
      join
      req = '0;
      eop = '0;
      repeat (20) tick();

      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(11) == 0) req[k] = ~req[k];
            eop[k] = ($urandom_range(5) == 0);
            din[k*8 +: 8] = 8'($urandom);
         end
         tick();
      end
      req = '0;
      eop = '0;
      repeat (30) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
